muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execute unit.
- Sits beside the single-cycle ALU in the execute stage. Control routes R-type ops with funct7 = 7'b0000001 here instead of through ALU operation selection.
- Accepts one operation per start handshake, computes over multiple cycles, and holds the result until the next start.
- The pipeline stalls on busy.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3/funct7 encodings and the controller state type.
package muldiv_unit_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // All divide-class ops share funct3[2]; remainders also set funct3[1].
  function automatic logic f3_is_div(logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: one bit per cycle shift-add multiply and
// restoring divide on magnitudes, with sign fix-up around the core.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | iterating, counter XLEN-1 down to 0
// DONE  | result valid for one cycle; a new start may be accepted
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t state, state_n;

  logic [2:0]        f3_reg;
  logic              neg_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic            accept;
  logic            a_signed, b_signed;
  logic            neg_a, neg_b, neg_res;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   final_res;

  assign accept = start && !kill && (state != BUSY);

  // Operand pre-processing: magnitudes for signed positions, sign of result.
  always_comb begin
    a_signed = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
               (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
    b_signed = (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
               (funct3 == FUNCT3_REM);
    neg_a    = a_signed & op_a[XLEN-1];
    neg_b    = b_signed & op_b[XLEN-1];
    a_abs    = neg_a ? (~op_a + 1'b1) : op_a;
    b_abs    = neg_b ? (~op_b + 1'b1) : op_b;
    neg_res  = f3_is_rem(funct3) ? neg_a : (neg_a ^ neg_b);
  end

  always_comb begin
    div_zero = f3_is_div(funct3) && (op_b == '0);
    overflow = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
               (op_a == INT_MIN) && (op_b == '1);
    special  = div_zero | overflow;
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? op_a : '1;
    else if (overflow)
      special_res = funct3[1] ? '0 : INT_MIN;
  end

  // One iteration step of either algorithm; acc holds {hi, lo} halves.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? a_reg : '0)};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_trial = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_trial - {1'b0, b_reg};
    div_ge    = ~div_diff[XLEN];
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0];
    div_next  = {div_rem, acc[XLEN-2:0], div_ge};
    acc_next  = f3_is_div(f3_reg) ? div_next : mul_next;
  end

  // Sign fix-up on the value the final iteration produces.
  always_comb begin
    prod_fix = neg_reg ? (~acc_next + 1'b1) : acc_next;
    quo_fix  = neg_reg ? (~acc_next[XLEN-1:0] + 1'b1) : acc_next[XLEN-1:0];
    rem_fix  = neg_reg ? (~acc_next[2*XLEN-1:XLEN] + 1'b1) : acc_next[2*XLEN-1:XLEN];
    case (f3_reg)
      FUNCT3_MUL:                              final_res = prod_fix[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                 final_res = quo_fix;
      default:                                 final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (kill)       state_n = IDLE;
        else if (start) state_n = special ? DONE : BUSY;
        else            state_n = IDLE;
      end
      BUSY: begin
        if (kill)            state_n = IDLE;
        else if (cnt == '0)  state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_reg  <= '0;
      neg_reg <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      f3_reg  <= funct3;
      neg_reg <= neg_res;
      a_reg   <= a_abs;
      b_reg   <= b_abs;
      cnt     <= CNT_W'(XLEN-1);
      // Multiplier shifts out of the low half; dividend shifts out likewise.
      acc     <= f3_is_div(funct3) ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
      if (special)
        result <= special_res;
    end else if (state == BUSY && !kill) begin
      acc <= acc_next;
      cnt <= cnt - CNT_W'(1);
      if (cnt == '0)
        result <= final_res;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at start,
// compared on each done pulse; latency, kill and async reset checked inline.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sbv, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    r = '0;
    case (f)
      3'b000: begin p = sa * sbv; r = p[31:0]; end
      3'b001: begin p = sa * sbv; r = p[63:32]; end
      3'b010: begin p = sa * ub;  r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: begin
        if (b == 0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = $signed(a) / $signed(b);
      end
      3'b101: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic is_special(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return f[2] && ((b == 0) ||
           ((f == 3'b100 || f == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Result scoreboard: every done pulse must match the oldest queued value.
  initial forever begin
    @(posedge clk);
    #1;
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else                   check("result", result, exp_q.pop_front());
    end
  end

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int extra);
    int n, nbusy, lat;
    lat = is_special(f, a, b) ? 1 : 33;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      if (n == extra) begin
        op_a = ~a; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("busy_cycles", 32'(nbusy), 32'(lat - 1));
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int nd;
    logic [2:0] rf;
    logic [31:0] ra, rb;

    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(FUNCT3_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    do_op(FUNCT3_MULH,   32'h80000000,   32'h80000000, 32'h40000000, 0);
    do_op(FUNCT3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    do_op(FUNCT3_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(FUNCT3_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 0);
    do_op(FUNCT3_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 0);
    do_op(FUNCT3_DIVU,   32'd100,        32'd7,        32'd14,       0);
    do_op(FUNCT3_REMU,   32'd100,        32'd7,        32'd2,        0);
    do_op(FUNCT3_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, 0);
    do_op(FUNCT3_REM,    32'd5,          32'd0,        32'd5,        0);
    do_op(FUNCT3_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0);
    do_op(FUNCT3_REM,    32'h80000000,   32'hFFFFFFFF, 32'd0,        0);

    // Second start at cycle 5 must be ignored.
    do_op(FUNCT3_MUL, 32'd3, 32'd4, 32'd12, 5);

    // Kill at cycle 10: no done, result keeps 12.
    @(negedge clk);
    funct3 = FUNCT3_MUL; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    nd = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("kill_no_done", 32'(nd), 32'd0);
    check("kill_result", result, 32'd12);

    // Asynchronous reset at cycle 20 of a DIV.
    @(negedge clk);
    funct3 = FUNCT3_DIV; op_a = 32'hFFFFFF9C; op_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(FUNCT3_DIVU, 32'd9, 32'd3, 32'd3, 0);

    for (int i = 0; i < 12; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'd0 : $urandom;
      if (i == 5) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; rf = FUNCT3_DIV; end
      do_op(rf, ra, rb, ref_model(rf, ra, rb), 0);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
